lsu_store_buffer: RTL and testbench

Posted store buffer between the LSU execute stage and the single-port data RAM. Stores from the LSU are queued and drained to RAM in cycles with no load. Loads always get the RAM port, and they take data from the youngest matching buffered store when one exists. Load data comes back one cycle after `rd_en`, which is the timing the LSU writeback stage already expects.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_sb_match.sv | 30 +++
 rtl/lsu_store_buffer.sv | 117 +++++++++++
 tb/tb_lsu_store_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: store-buffer entry layout and sizing constants.
package lsu_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int WORD_ADDR_W      = 30;

  typedef struct packed {
    logic                   valid;
    logic [WORD_ADDR_W-1:0] waddr;
    logic [31:0]            data;
  } sb_entry_t;

endpackage

// File: rtl/lsu_sb_match.sv
// Youngest-match search over the store buffer for load forwarding.
module lsu_sb_match
  import lsu_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t              i_entries [DEPTH],
  input  logic [PTR_W-1:0]       i_tail,
  input  logic [WORD_ADDR_W-1:0] i_waddr,
  output logic                   o_hit,
  output logic [31:0]            o_data
);

  // Walk from oldest (tail-DEPTH) to youngest (tail-1) so later hits override.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_tail - PTR_W'(k);
      if (i_entries[w_idx].valid && (i_entries[w_idx].waddr == i_waddr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Posted store buffer in front of the single-port data RAM; loads own the
// port and forward from the youngest buffered store, stores drain when idle.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [31:0] rd_addr,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        sb_stall,
  output logic        sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic             r_hit;
  logic [31:0]      r_hit_data;

  logic             w_load;
  logic             w_drain;
  logic             w_enq;
  logic             w_hit;
  logic [31:0]      w_hit_data;
  logic             w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  assign sb_stall = (r_count == CNT_W'(DEPTH));
  assign sb_empty = (r_count == '0);

  assign w_load  = rd_en && !rst;
  assign w_drain = !rd_en && !sb_empty && !rst;
  assign w_enq   = wr_en && !sb_stall;

  lsu_sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .i_entries (r_entries),
    .i_tail    (r_tail),
    .i_waddr   (rd_addr[31:2]),
    .o_hit     (w_hit),
    .o_data    (w_hit_data)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_load) begin
      mem_re   = 1'b1;
      mem_addr = {rd_addr[31:2], 2'b00};
    end else if (w_drain) begin
      mem_we    = 1'b1;
      mem_addr  = {r_entries[r_head].waddr, 2'b00};
      mem_wdata = r_entries[r_head].data;
    end
  end

  // Enqueue and drain never touch the same slot: that needs count 0 or full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_entries[r_tail] <= '{valid: 1'b1, waddr: wr_addr[31:2], data: wr_data};
        r_tail            <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_data <= '0;
    end else begin
      r_rd_valid <= w_load;
      r_hit      <= w_load && w_hit;
      r_hit_data <= w_hit_data;
    end
  end

  assign rd_data = !r_rd_valid ? 32'h0 : (r_hit ? r_hit_data : mem_rdata);

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed vector bench for lsu_store_buffer with a behavioural RAM model.
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        wr_en, rd_en;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = 32'h0;
  logic        sb_stall, sb_empty;

  always #5 clk = ~clk;

  lsu_store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .sb_stall  (sb_stall),
    .sb_empty  (sb_empty)
  );

  // RAM model: unwritten words read back as 0x55, read data one cycle later.
  logic [31:0] ramMem [logic [29:0]];
  always @(posedge clk) begin
    if (mem_we) ramMem[mem_addr[31:2]] = mem_wdata;
    if (mem_re) mem_rdata <= ramMem.exists(mem_addr[31:2]) ? ramMem[mem_addr[31:2]] : 32'h55;
  end

  typedef struct {
    logic        rst;
    logic        wrEn;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        rdEn;
    logic [31:0] rdAddr;
    logic        expWe;
    logic        expRe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic        expStall;
    logic        expEmpty;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  function automatic void addVec(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [31:0] ra,
                                 input logic eWe, input logic eRe, input logic [31:0] eAddr, input logic [31:0] eWd,
                                 input logic eStall, input logic eEmpty, input logic [31:0] eRd);
    vec_t v;
    v = '{r, we, wa, wd, re, ra, eWe, eRe, eAddr, eWd, eStall, eEmpty, eRd};
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL v%0d %s got=%h want=%h", idx, name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst     = v.rst;
    wr_en   = v.wrEn;
    wr_addr = v.wrAddr;
    wr_data = v.wrData;
    rd_en   = v.rdEn;
    rd_addr = v.rdAddr;
    #1;
  endtask

  // Fill under loads, hold a fifth store, then let everything drain.
  task automatic runFillDrain;
    logic [31:0] gotA[$];
    logic [31:0] gotD[$];
    logic        clearWr;
    logic        done;
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 32'h900 + 32'(4 * i); wr_data = 32'hC0 + 32'(i);
      rd_en = 1'b1; rd_addr = 32'h800;
      @(negedge clk);
    end
    wr_addr = 32'h910; wr_data = 32'hC4;
    #1;
    vectorsApplied++;
    checkOutput("seq_stall_full", 0, 32'(sb_stall), 32'd1);
    @(negedge clk);
    rd_en   = 1'b0;
    clearWr = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (c != 0) @(negedge clk);
      if (clearWr) wr_en = 1'b0;
      #1;
      if (mem_we) begin
        gotA.push_back(mem_addr);
        gotD.push_back(mem_wdata);
      end
      if (wr_en && !sb_stall) clearWr = 1'b1;
      if (sb_empty && !wr_en) done = 1'b1;
    end
    vectorsApplied++;
    checkOutput("seq_drain_timeout", 0, 32'(done), 32'd1);
    vectorsApplied++;
    checkOutput("seq_drain_count", 0, 32'(gotA.size()), 32'd5);
    for (int i = 0; i < 5 && i < gotA.size(); i++) begin
      vectorsApplied++;
      checkOutput("seq_drain_addr", i, gotA[i], 32'h900 + 32'(4 * i));
      checkOutput("seq_drain_data", i, gotD[i], 32'hC0 + 32'(i));
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    //     rst we  waddr     wdata         re  raddr     eWe eRe eAddr     eWdata        stl emp eRd
    addVec(1, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h200, 32'h11,       0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h200, 0, 1, 32'h200, 32'h0,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h200, 0, 1, 32'h200, 32'h0,        0, 0, 32'h11);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h200, 32'h11,       0, 0, 32'h11);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h300, 32'hA,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h300, 32'hB,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h300, 0, 1, 32'h300, 32'h0,        0, 0, 32'h55);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h300, 32'hA,        0, 0, 32'hB);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h300, 32'hB,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h300, 0, 1, 32'h300, 32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'hB);
    addVec(0, 1, 32'h400, 32'h1,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h404, 32'h2,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(0, 1, 32'h408, 32'h3,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(0, 1, 32'h40C, 32'h4,        1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(0, 1, 32'h410, 32'h5,        1, 32'h800, 0, 1, 32'h800, 32'h0,        1, 0, 32'h55);
    addVec(0, 1, 32'h410, 32'h5,        1, 32'h800, 0, 1, 32'h800, 32'h0,        1, 0, 32'h55);
    addVec(0, 1, 32'h410, 32'h5,        0, 32'h0,   1, 0, 32'h400, 32'h1,        1, 0, 32'h55);
    addVec(0, 1, 32'h410, 32'h5,        0, 32'h0,   1, 0, 32'h404, 32'h2,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h410, 0, 1, 32'h410, 32'h0,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h408, 32'h3,        0, 0, 32'h5);
    addVec(0, 1, 32'h500, 32'h77,       0, 32'h0,   1, 0, 32'h40C, 32'h4,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h410, 32'h5,        0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h500, 32'h77,       0, 0, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h600, 32'hA1,       1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 1, 32'h0);
    addVec(0, 1, 32'h604, 32'hA2,       1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(0, 1, 32'h608, 32'hA3,       1, 32'h800, 0, 1, 32'h800, 32'h0,        0, 0, 32'h55);
    addVec(1, 0, 32'h0,   32'h0,        1, 32'h800, 0, 0, 32'h0,   32'h0,        0, 0, 32'h55);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        1, 32'h600, 0, 1, 32'h600, 32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h55);
    addVec(0, 1, 32'h700, 32'h99,       1, 32'h700, 0, 1, 32'h700, 32'h0,        0, 1, 32'h0);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   1, 0, 32'h700, 32'h99,       0, 0, 32'h55);
    addVec(0, 0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 1, 32'h0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      vectorsApplied++;
      checkOutput("mem_we",    i, 32'(mem_we),   32'(vecs[i].expWe));
      checkOutput("mem_re",    i, 32'(mem_re),   32'(vecs[i].expRe));
      checkOutput("mem_addr",  i, mem_addr,      vecs[i].expAddr);
      checkOutput("mem_wdata", i, mem_wdata,     vecs[i].expWdata);
      checkOutput("sb_stall",  i, 32'(sb_stall), 32'(vecs[i].expStall));
      checkOutput("sb_empty",  i, 32'(sb_empty), 32'(vecs[i].expEmpty));
      checkOutput("rd_data",   i, rd_data,       vecs[i].expRd);
    end

    runFillDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
